sinegen_ctrl: RTL and testbench
===============================

// Module: sinegen_ctrl
// PURPOSE
//  Phase-accumulator sequencer that drives both address ports of the dual-port sine ROM.
//  Latches a config (step, port-2 phase offset, sample count), runs continuous or N-sample bursts,
//  and flags when ROM data is valid, accounting for the ROM's 1-cycle registered read latency.
//  Sits between the control/config source and the ROM.
// PARAMETERS
//  ADDRESS_WIDTH  8   ROM address width; must be <= ACC_WIDTH
//  ACC_WIDTH      16  phase accumulator width; addr = acc[ACC_WIDTH-1 -: ADDRESS_WIDTH]
//  CNT_WIDTH      16  burst sample-count width
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous, active-low reset
//  cfg_valid     in   1              config offer
//  cfg_ready     out  1              config accepted when cfg_valid&&cfg_ready; = (state==IDLE)
//  cfg_incr      in   ACC_WIDTH      phase step per sample
//  cfg_offset    in   ADDRESS_WIDTH  addr2 offset from addr1
//  cfg_count     in   CNT_WIDTH      samples per run; 0 = continuous
//  start         in   1              begin run (IDLE only)
//  stop          in   1              end run (RUN only)
//  addr1         out  ADDRESS_WIDTH  ROM port-1 address
//  addr2         out  ADDRESS_WIDTH  ROM port-2 address = addr1 + offset_r, mod 2^ADDRESS_WIDTH
//  sample_valid  out  1              ROM dout1/dout2 hold a sample issued by this run
//  busy          out  1              state != IDLE
//  done          out  1              1-cycle pulse, high in the DRAIN cycle
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, incr_r/offset_r/count_r=0, issued=0.
//    addr1=addr2=0, sample_valid=0, done=0, busy=0, cfg_ready=1.
//  - Reset is asynchronous and takes effect mid-run: outputs go to reset values at once.
//    Config is also cleared.
//  - States: IDLE -> RUN -> DRAIN -> IDLE.
//  - IDLE: a cfg handshake latches incr/offset/count; acc is held, so addresses stay stable.
//    start: next edge acc<=0, issued<=0, ->RUN.
//    If cfg handshake and start fall in the same cycle, the new config applies to that run.
//  - IDLE: stop is ignored.
//  - RUN: one address pair issued every cycle. Each edge: acc<=acc+incr_r (wraps mod 2^ACC_WIDTH), issued++.
//  - RUN -> DRAIN when stop=1, or count_r!=0 && issued+1==count_r.
//    The address in that cycle is the last one issued. stop plus terminal count in the same cycle gives one DRAIN.
//  - RUN: start, cfg_valid ignored; cfg_ready=0.
//  - DRAIN: exactly 1 cycle, then IDLE. done=1; start/stop ignored.
//  - sample_valid: a register set iff the state was RUN in the previous cycle.
//    It aligns with ROM dout for that address. N issued addresses give exactly N sample_valid cycles.
//  - Latency: start at edge 0; first address at cycle 1; first sample_valid at cycle 2.
//  - issued saturates at max and is not compared when count_r==0.
//  - incr_r==0 is legal: constant address.
// CONFIGURATION
//  - WRAP_PULSE_EN defined: adds output wrap_pulse (1 bit, reset 0).
//    It is high together with sample_valid for the sample whose address was issued in the first cycle
//    after an accumulator carry-out (phase wrap).
//    The first sample of a run does not pulse.
//  - WRAP_PULSE_EN undefined: no port, no carry logic.
// TESTING (ADDRESS_WIDTH=8, ACC_WIDTH=16)
//  1. cfg incr=0x0100, offset=0x40, count=4, then start.
//     -> addr1 0,1,2,3 and addr2 0x40..0x43 on consecutive cycles.
//     -> sample_valid 4 cycles, starting 1 cycle later; done with the 4th; busy 5 cycles.
//  2. incr=0x8000, count=0, stop in the 10th RUN cycle.
//     -> addr1 alternates 0x00/0x80; exactly 10 sample_valid cycles; done once.
//  3. offset=0xC0, run until addr1=0x50 -> addr2=0x10 (modular wrap).
//  4. cfg_valid with incr=0x0200 during RUN -> cfg_ready=0; next run still steps by 0x0100.
//  5. rst_n low during RUN -> busy/sample_valid/addr immediately 0.
//     After release, a new cfg handshake plus start runs normally.
//  6. [WRAP_PULSE_EN] incr=0x4000, count=6.
//     -> addr1 0,0x40,0x80,0xC0,0x00,0x40; wrap_pulse only with the 5th sample_valid.
//  7. cfg_valid+start in the same IDLE cycle, count=2 -> new config used; 2 samples.

Source files
------------

// File: rtl/sinegen_ctrl.sv
// Phase-accumulator sequencer that drives both address ports of a dual-port sine ROM.
// Optional feature macro: WRAP_PULSE_EN adds a wrap_pulse output that marks the first sample after a phase wrap.
module sinegen_ctrl #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int ACC_WIDTH     = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACC_WIDTH-1:0]     cfg_incr,
  input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
  input  logic [CNT_WIDTH-1:0]     cfg_count,
  input  logic                     start,
  input  logic                     stop,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [ADDRESS_WIDTH-1:0] addr2,
  output logic                     sample_valid,
  output logic                     busy,
  output logic                     done
`ifdef WRAP_PULSE_EN
  ,
  output logic                     wrap_pulse
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                   state_r;
  state_t                   state_nxt;
  logic [ACC_WIDTH-1:0]     acc_r;
  logic [ACC_WIDTH-1:0]     incr_r;
  logic [ADDRESS_WIDTH-1:0] offset_r;
  logic [CNT_WIDTH-1:0]     count_r;
  logic [CNT_WIDTH-1:0]     issued_r;
  logic                     sample_valid_r;
  logic [CNT_WIDTH:0]       issued_plus1;
  logic                     terminal;
  logic [ACC_WIDTH-1:0]     acc_nxt;

`ifdef WRAP_PULSE_EN
  logic                     carry_r;
  logic                     wrap_pulse_r;
  logic [ACC_WIDTH:0]       acc_sum;
  assign acc_sum = {1'b0, acc_r} + {1'b0, incr_r};
  assign acc_nxt = acc_sum[ACC_WIDTH-1:0];
`else
  assign acc_nxt = acc_r + incr_r;
`endif

  // Widened compare so a saturated issued counter can never alias to a small count.
  assign issued_plus1 = {1'b0, issued_r} + {CNT_ZERO, 1'b1};
  assign terminal     = (count_r != CNT_ZERO) && (issued_plus1 == {1'b0, count_r});

  assign addr1        = acc_r[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  assign addr2        = addr1 + offset_r;
  assign sample_valid = sample_valid_r;
  assign busy         = (state_r != IDLE);
  assign done         = (state_r == DRAIN);
  assign cfg_ready    = (state_r == IDLE);

  // Next-state decode for the IDLE -> RUN -> DRAIN -> IDLE sequence.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt = RUN;
        else       state_nxt = IDLE;
      end
      RUN: begin
        if (stop || terminal) state_nxt = DRAIN;
        else                  state_nxt = RUN;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator, config and sample-valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      acc_r          <= {ACC_WIDTH{1'b0}};
      incr_r         <= {ACC_WIDTH{1'b0}};
      offset_r       <= {ADDRESS_WIDTH{1'b0}};
      count_r        <= CNT_ZERO;
      issued_r       <= CNT_ZERO;
      sample_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nxt;
      // ROM read latency is one cycle, so data is valid the cycle after a RUN address.
      sample_valid_r <= (state_r == RUN);
      case (state_r)
        IDLE: begin
          if (cfg_valid) begin
            incr_r   <= cfg_incr;
            offset_r <= cfg_offset;
            count_r  <= cfg_count;
          end
          if (start) begin
            acc_r    <= {ACC_WIDTH{1'b0}};
            issued_r <= CNT_ZERO;
          end
        end
        RUN: begin
          acc_r <= acc_nxt;
          if (issued_r != CNT_MAX) issued_r <= issued_r + CNT_ONE;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

`ifdef WRAP_PULSE_EN
  // carry_r marks the RUN cycle whose address follows a carry-out; the pulse rides with its sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r      <= 1'b0;
      wrap_pulse_r <= 1'b0;
    end else begin
      wrap_pulse_r <= (state_r == RUN) && carry_r;
      if (state_r == RUN) carry_r <= acc_sum[ACC_WIDTH];
      else                carry_r <= 1'b0;
    end
  end

  assign wrap_pulse = wrap_pulse_r;
`endif

endmodule

// File: tb/tb_sinegen_ctrl.sv
// Self-checking bench for sinegen_ctrl: an identity ROM model feeds a scoreboard of expected samples.
module tb_sinegen_ctrl;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_incr;
  logic [7:0]  cfg_offset;
  logic [15:0] cfg_count;
  logic        start;
  logic        stop;
  logic [7:0]  addr1;
  logic [7:0]  addr2;
  logic        sample_valid;
  logic        busy;
  logic        done;
`ifdef WRAP_PULSE_EN
  logic        wrap_pulse;
`endif

  sinegen_ctrl #(.ADDRESS_WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_incr     (cfg_incr),
    .cfg_offset   (cfg_offset),
    .cfg_count    (cfg_count),
    .start        (start),
    .stop         (stop),
    .addr1        (addr1),
    .addr2        (addr2),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
`ifdef WRAP_PULSE_EN
    ,
    .wrap_pulse   (wrap_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a1;
    logic [7:0] a2;
    logic       w;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   sv_count    = 0;

  // Identity ROM with a registered read: dout equals the address presented one edge earlier.
  logic [7:0] dout1;
  logic [7:0] dout2;
  always @(posedge clk) begin
    dout1 <= addr1;
    dout2 <= addr2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_acc(input int k, input logic [15:0] incr);
    logic [31:0] p;
    p = k * incr;
    return p[15:0];
  endfunction

  function automatic logic [7:0] exp_a1(input int k, input logic [15:0] incr);
    logic [15:0] a;
    a = exp_acc(k, incr);
    return a[15:8];
  endfunction

  function automatic logic exp_wrap(input int k, input logic [15:0] incr);
    logic [16:0] s;
    if (k < 1) return 1'b0;
    s = {1'b0, exp_acc(k - 1, incr)} + {1'b0, incr};
    return s[16];
  endfunction

  // Scoreboard consumer: every sample_valid must match the next expected ROM output.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sample_valid) begin
      if (q.size() == 0) begin
        chk("extra_sample", {31'd0, sample_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("dout1", {24'd0, dout1}, {24'd0, e.a1});
        chk("dout2", {24'd0, dout2}, {24'd0, e.a2});
`ifdef WRAP_PULSE_EN
        chk("wrap_pulse", {31'd0, wrap_pulse}, {31'd0, e.w});
`endif
      end
      sv_count++;
    end else begin
`ifdef WRAP_PULSE_EN
      if (rst_n) chk("wrap_idle", {31'd0, wrap_pulse}, 32'd0);
`endif
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr1"}, {24'd0, addr1}, 32'd0);
    chk({tag, "_addr2"}, {24'd0, addr2}, 32'd0);
    chk({tag, "_sv"}, {31'd0, sample_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, cfg_ready}, 32'd1);
  endtask

  // One run: optional cfg handshake, start, per-cycle address checks, stop/reset injection.
  task automatic run(input logic [15:0] incr, input logic [7:0] off, input logic [15:0] cnt,
                     input int stop_at, input int rst_at, input bit do_cfg,
                     input bit same_cycle, input bit poke_cfg);
    int n;
    int c;
    int sv0;
    bit seen_done;
    exp_t e;
    if (rst_at > 0) n = rst_at - 1;
    else if (cnt != 16'd0 && (stop_at == 0 || int'(cnt) <= stop_at)) n = int'(cnt);
    else n = stop_at;
    for (int k = 0; k < n; k++) begin
      e.a1 = exp_a1(k, incr);
      e.a2 = e.a1 + off;
      e.w  = exp_wrap(k, incr);
      q.push_back(e);
    end
    sv0 = sv_count;
    if (same_cycle) begin
      @(negedge clk);
      cfg_valid = 1'b1; cfg_incr = incr; cfg_offset = off; cfg_count = cnt; start = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b0;
    end else begin
      @(negedge clk);
      if (do_cfg) begin
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1; cfg_incr = incr; cfg_offset = off; cfg_count = cnt;
        @(negedge clk);
        cfg_valid = 1'b0;
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    c = 1;
    seen_done = 1'b0;
    while (!seen_done && c <= 300) begin
      if (rst_at == c) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrun_rst");
        #1 rst_n = 1'b1;
        break;
      end
      chk("busy_run", {31'd0, busy}, 32'd1);
      if (done) begin
        seen_done = 1'b1;
        chk("drain_cycle", c, n + 1);
      end else begin
        chk("addr1", {24'd0, addr1}, {24'd0, exp_a1(c - 1, incr)});
        chk("addr2", {24'd0, addr2}, {24'd0, exp_a1(c - 1, incr) + off});
        chk("cfg_ready_run", {31'd0, cfg_ready}, 32'd0);
        if (poke_cfg && c == 2) begin
          cfg_valid = 1'b1; cfg_incr = 16'h0200; cfg_count = 16'd1;
        end else begin
          cfg_valid = 1'b0;
        end
        stop = (stop_at == c);
      end
      @(negedge clk);
      c++;
    end
    stop = 1'b0;
    cfg_valid = 1'b0;
    if (rst_at == 0) begin
      if (!seen_done) chk("done_timeout", {31'd0, done}, 32'd1);
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("done_after", {31'd0, done}, 32'd0);
    end
    chk("sample_count", sv_count - sv0, n);
    chk("queue_empty", q.size(), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    cfg_valid = 1'b0; cfg_incr = 16'd0; cfg_offset = 8'd0; cfg_count = 16'd0;
    start = 1'b0; stop = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("post_reset");

    // Basic 4-sample burst with offset.
    run(16'h0100, 8'h40, 16'd4, 0, 0, 1'b1, 1'b0, 1'b0);
    // stop is ignored in IDLE and the address holds where the run left it.
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);
    chk("idle_addr_hold", {24'd0, addr1}, 32'h04);

    // Continuous half-cycle step, stopped in the 10th RUN cycle.
    run(16'h8000, 8'h00, 16'd0, 10, 0, 1'b1, 1'b0, 1'b0);
    // Offset wraps modulo 256: addr1 0x50 gives addr2 0x10.
    run(16'h1000, 8'hC0, 16'd6, 0, 0, 1'b1, 1'b0, 1'b0);
    // cfg offered during RUN is refused; the following run keeps the old step.
    run(16'h0100, 8'h40, 16'd0, 5, 0, 1'b1, 1'b0, 1'b1);
    run(16'h0100, 8'h40, 16'd0, 4, 0, 1'b0, 1'b0, 1'b0);
    // Stop and terminal count in the same cycle give a single DRAIN.
    run(16'h0100, 8'h40, 16'd3, 3, 0, 1'b1, 1'b0, 1'b0);
    // Async reset in the middle of a run, then a normal run.
    run(16'h0100, 8'h10, 16'd0, 0, 4, 1'b1, 1'b0, 1'b0);
    run(16'h0300, 8'h20, 16'd3, 0, 0, 1'b1, 1'b0, 1'b0);
    // Boundaries: single sample, zero step.
    run(16'h0100, 8'h00, 16'd1, 0, 0, 1'b1, 1'b0, 1'b0);
    run(16'h0000, 8'h80, 16'd3, 0, 0, 1'b1, 1'b0, 1'b0);
    // Quarter step: the 5th sample follows the phase wrap.
    run(16'h4000, 8'h00, 16'd6, 0, 0, 1'b1, 1'b0, 1'b0);
    // cfg and start in the same IDLE cycle: new config applies.
    run(16'h0700, 8'h08, 16'd2, 0, 0, 1'b1, 1'b1, 1'b0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
